// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: per key a 2-FF synchroniser, an exact-count
// debounce FSM, and registered level / press / release / long-press / auto-repeat outputs.
module key_debounce_multi #(
  parameter int N_KEYS          = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] D_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] L_LAST    = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] R_LAST    = HW'(REPEAT_CYCLES - 1);
  localparam logic          PIN_IDLE  = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("key_debounce_multi: every *_CYCLES parameter must be >= 2");
  end

  logic [N_KEYS-1:0] level_ev, press_ev, release_ev, long_ev, repeat_ev;
  logic [N_KEYS-1:0] level_q, press_q, release_q, long_q, repeat_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic          s1, s2, p;
    state_t        state, state_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic          long_done, long_done_nxt;
    logic          ev_press, ev_release, ev_long, ev_repeat;

    // NOTE: the synchroniser resets to the idle pin level, so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1 <= PIN_IDLE;
        s2 <= PIN_IDLE;
      end else begin
        s1 <= key_in[i];
        s2 <= s1;
      end
    end

    assign p = s2 ^ PIN_IDLE;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= RELEASED;
        dcnt      <= '0;
        hcnt      <= '0;
        long_done <= 1'b0;
      end else begin
        state     <= state_nxt;
        dcnt      <= dcnt_nxt;
        hcnt      <= hcnt_nxt;
        long_done <= long_done_nxt;
      end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
      state_nxt     = state;
      dcnt_nxt      = dcnt;
      hcnt_nxt      = hcnt;
      long_done_nxt = long_done;
      ev_press      = 1'b0;
      ev_release    = 1'b0;
      ev_long       = 1'b0;
      ev_repeat     = 1'b0;
      case (state)
        RELEASED: begin
          if (p) begin
            state_nxt = PRESS_CHK;
            dcnt_nxt  = DW'(1);
          end
        end
        PRESS_CHK: begin
          if (!p) begin
            state_nxt = RELEASED;
            dcnt_nxt  = '0;
          end else if (dcnt == D_LAST) begin
            state_nxt     = PRESSED;
            dcnt_nxt      = '0;
            hcnt_nxt      = '0;
            long_done_nxt = 1'b0;
            ev_press      = 1'b1;
          end else begin
            dcnt_nxt = dcnt + 1'b1;
          end
        end
        PRESSED: begin
          // Hold timing counts every PRESSED cycle, including the one that leaves on a bounce,
          // so a bounce delays key_long by exactly the cycles spent in RELEASE_CHK.
          if (!long_done) begin
            if (hcnt == L_LAST) begin
              ev_long       = 1'b1;
              long_done_nxt = 1'b1;
              hcnt_nxt      = '0;
            end else begin
              hcnt_nxt = hcnt + 1'b1;
            end
          end else if (REPEAT_EN != 0) begin
            if (hcnt == R_LAST) begin
              ev_repeat = 1'b1;
              hcnt_nxt  = '0;
            end else begin
              hcnt_nxt = hcnt + 1'b1;
            end
          end
          if (!p) begin
            state_nxt = RELEASE_CHK;
            dcnt_nxt  = DW'(1);
          end
        end
        RELEASE_CHK: begin
          if (p) begin
            state_nxt = PRESSED;
            dcnt_nxt  = '0;
          end else if (dcnt == D_LAST) begin
            state_nxt  = RELEASED;
            dcnt_nxt   = '0;
            ev_release = 1'b1;
          end else begin
            dcnt_nxt = dcnt + 1'b1;
          end
        end
        default: state_nxt = RELEASED;
      endcase
    end

    assign level_ev[i]   = (state_nxt == PRESSED) || (state_nxt == RELEASE_CHK);
    assign press_ev[i]   = ev_press;
    assign release_ev[i] = ev_release;
    assign long_ev[i]    = ev_long;
    assign repeat_ev[i]  = ev_repeat;
  end

  // Events are captured alongside the state change, then retimed once more so every
  // output leaves the block straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      repeat_q    <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_long    <= '0;
      key_repeat  <= '0;
    end else begin
      level_q     <= level_ev;
      press_q     <= press_ev;
      release_q   <= release_ev;
      long_q      <= long_ev;
      repeat_q    <= repeat_ev;
      key_level   <= level_q;
      key_press   <= press_q;
      key_release <= release_q;
      key_long    <= long_q;
      key_repeat  <= repeat_q;
    end
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: a table of key patterns plus hand-written long/repeat,
// bounce, simultaneous and reset sequences; pulses are checked against a timed scoreboard.
module tb_key_debounce_multi;

  localparam int DEB = 8;
  localparam int LNG = 40;
  localparam int RPT = 16;
  // Input driven on a falling edge is sampled at the next rising edge E; a pulse is
  // visible in the cycle after edge E+DEB+2.
  localparam int LAT = DEB + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_a, key_b;
  logic [1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
  logic [1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;

  key_debounce_multi #(
    .N_KEYS(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LNG), .REPEAT_EN(1), .REPEAT_CYCLES(RPT)
  ) dut_a (
    .clk(clk), .rst(rst), .key_in(key_a),
    .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a),
    .key_long(lng_a), .key_repeat(rep_a)
  );

  key_debounce_multi #(
    .N_KEYS(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LNG), .REPEAT_EN(0), .REPEAT_CYCLES(RPT)
  ) dut_b (
    .clk(clk), .rst(rst), .key_in(key_b),
    .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b),
    .key_long(lng_b), .key_repeat(rep_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2, EV_REPEAT = 3} ev_kind_t;
  typedef struct {
    int       at;
    int       dut;
    int       ch;
    ev_kind_t kind;
  } ev_t;

  typedef struct {
    logic [1:0] key;
    int         hold;
    logic [1:0] lvl;
    logic [1:0] press;
    logic [1:0] rel;
  } vec_t;

  ev_t   sb[$];
  vec_t  vec[8];
  string kname[4] = '{"press", "release", "long", "repeat"};
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int at, input int dut, input int ch, input ev_kind_t kind);
    ev_t e;
    e.at = at; e.dut = dut; e.ch = ch; e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [1:0] pulses(input int dut, input int kind);
    logic [1:0] r;
    r = 2'b00;
    case (kind)
      0: r = (dut == 0) ? prs_a : prs_b;
      1: r = (dut == 0) ? rel_a : rel_b;
      2: r = (dut == 0) ? lng_a : lng_b;
      3: r = (dut == 0) ? rep_a : rep_b;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Every cycle, each pulse output is matched against the entries scheduled for this cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          for (int ch = 0; ch < 2; ch++) begin
            logic [1:0] obs;
            int         hit;
            obs = pulses(d, k);
            hit = -1;
            foreach (sb[j])
              if (sb[j].at == cyc && sb[j].dut == d && sb[j].ch == ch && int'(sb[j].kind) == k)
                hit = j;
            if (obs[ch] || hit >= 0) begin
              check($sformatf("%s dut%0d ch%0d", kname[k], d, ch), 32'(obs[ch]), 32'(hit >= 0));
              if (hit >= 0) sb.delete(hit);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    // Clean press/release on channel 0, then bounces that must be rejected, then an accepted press.
    vec[0] = '{2'b10, 20, 2'b01, 2'b01, 2'b00};
    vec[1] = '{2'b11, 20, 2'b00, 2'b00, 2'b01};
    vec[2] = '{2'b10,  5, 2'b00, 2'b00, 2'b00};
    vec[3] = '{2'b11,  3, 2'b00, 2'b00, 2'b00};
    vec[4] = '{2'b10,  7, 2'b00, 2'b00, 2'b00};
    vec[5] = '{2'b11, 12, 2'b00, 2'b00, 2'b00};
    vec[6] = '{2'b10, 12, 2'b01, 2'b01, 2'b00};
    vec[7] = '{2'b11, 14, 2'b00, 2'b00, 2'b01};

    rst   = 1'b1;
    key_a = 2'b11;
    key_b = 2'b11;
    step(3);
    check("reset outputs dut_a", {lvl_a, prs_a, rel_a, lng_a, rep_a}, 0);
    check("reset outputs dut_b", {lvl_b, prs_b, rel_b, lng_b, rep_b}, 0);
    rst    = 1'b0;
    mon_on = 1'b1;
    step(5);

    foreach (vec[r]) begin
      key_a = vec[r].key;
      for (int ch = 0; ch < 2; ch++) begin
        if (vec[r].press[ch]) expect_ev(cyc + LAT, 0, ch, EV_PRESS);
        if (vec[r].rel[ch])   expect_ev(cyc + LAT, 0, ch, EV_RELEASE);
      end
      step(vec[r].hold);
      check($sformatf("row%0d level", r), lvl_a, vec[r].lvl);
    end

    // Long press with repeats on channel 1, released 120 cycles after key_press.
    c = cyc;
    key_a = 2'b01;
    expect_ev(c + LAT, 0, 1, EV_PRESS);
    expect_ev(c + LAT + LNG, 0, 1, EV_LONG);
    for (int n = 1; n <= 5; n++) expect_ev(c + LAT + LNG + n * RPT, 0, 1, EV_REPEAT);
    step(60);
    check("long hold level", lvl_a, 2'b10);
    step(LAT + 120 - 60);
    key_a = 2'b11;
    expect_ev(cyc + LAT, 0, 1, EV_RELEASE);
    step(15);
    check("long hold released level", lvl_a, 2'b00);

    // 4-cycle release bounce 30 cycles into the hold: no release, key_long 4 cycles late.
    c = cyc;
    key_a = 2'b01;
    expect_ev(c + LAT, 0, 1, EV_PRESS);
    expect_ev(c + LAT + LNG + 4, 0, 1, EV_LONG);
    step(LAT + 30);
    key_a = 2'b11;
    step(4);
    key_a = 2'b01;
    step(15);
    check("level through release bounce", lvl_a, 2'b10);
    key_a = 2'b11;
    expect_ev(cyc + LAT, 0, 1, EV_RELEASE);
    step(15);
    check("bounce test released level", lvl_a, 2'b00);

    // Both keys on both instances; dut_b has repeats disabled.
    c = cyc;
    key_a = 2'b00;
    key_b = 2'b00;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 2; ch++) begin
        expect_ev(c + LAT, d, ch, EV_PRESS);
        expect_ev(c + LAT + LNG, d, ch, EV_LONG);
        expect_ev(c + 100 + LAT, d, ch, EV_RELEASE);
        if (d == 0)
          for (int n = 1; n <= 3; n++) expect_ev(c + LAT + LNG + n * RPT, d, ch, EV_REPEAT);
      end
    end
    step(LAT);
    check("simultaneous press dut_a", prs_a, 2'b11);
    check("simultaneous press dut_b", prs_b, 2'b11);
    step(100 - LAT);
    check("simultaneous level dut_b", lvl_b, 2'b11);
    key_a = 2'b11;
    key_b = 2'b11;
    step(15);
    check("simultaneous released dut_a", lvl_a, 2'b00);

    // Reset 20 cycles after key_press with the key still held.
    c = cyc;
    key_a = 2'b10;
    expect_ev(c + LAT, 0, 0, EV_PRESS);
    step(LAT + 20);
    check("level before mid-hold reset", lvl_a, 2'b01);
    rst = 1'b1;
    #1;
    check("outputs during mid-hold reset", {lvl_a, prs_a, rel_a, lng_a, rep_a}, 0);
    step(2);
    rst = 1'b0;
    expect_ev(cyc + LAT, 0, 0, EV_PRESS);
    step(LAT - 1);
    check("level still low before re-press", lvl_a, 2'b00);
    step(20);
    check("level after re-press", lvl_a, 2'b01);
    key_a = 2'b11;
    expect_ev(cyc + LAT, 0, 0, EV_RELEASE);
    step(15);
    check("final released level", lvl_a, 2'b00);

    step(5);
    check("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
